// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the data memory controller: RV32 load/store
//   funct3 encodings, the controller state encoding and the access-legality
//   helper used when a CPU request is accepted.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
   localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
   localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
   localparam logic [2:0] F3_BU = 3'b100;  // LBU (no store form)
   localparam logic [2:0] F3_HU = 3'b101;  // LHU (no store form)

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      LDWR   = 2'd3
   } state_t;

   // True when the request must be rejected without touching memory:
   // misaligned half/word, unused funct3 codes, or unsigned store forms.
   function automatic logic access_illegal(input logic       we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] byte_off);
      logic illegal;
      case (funct3)
         F3_B:    illegal = 1'b0;
         F3_H:    illegal = byte_off[0];
         F3_W:    illegal = (byte_off != 2'b00);
         F3_BU:   illegal = we;
         F3_HU:   illegal = we | byte_off[0];
         default: illegal = 1'b1;
      endcase
      return illegal;
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane
//   Purely combinational byte-lane logic for the data memory controller.
//   Ports:
//     funct3   in  3   access type (B/H/W/BU/HU)
//     byte_off in  2   byte offset within the word (addr[1:0])
//     word     in  32  current memory word
//     wdata    in  32  store data (low bytes used for SB/SH)
//     rdata    out 32  extracted and sign/zero-extended load value
//     merged   out 32  memory word with the addressed lane(s) replaced
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [31:0] merged
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection and load extension.
   always_comb begin
      byte_s = word[7:0];
      half_s = word[15:0];
      rdata  = 32'd0;
      case (byte_off)
         2'd0:    byte_s = word[7:0];
         2'd1:    byte_s = word[15:8];
         2'd2:    byte_s = word[23:16];
         2'd3:    byte_s = word[31:24];
         default: byte_s = word[7:0];
      endcase
      // Half-word offsets are only ever 0 or 2 here; odd ones are rejected earlier.
      if (byte_off[1]) begin
         half_s = word[31:16];
      end else begin
         half_s = word[15:0];
      end
      case (funct3)
         F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
         F3_H:    rdata = {{16{half_s[15]}}, half_s};
         F3_W:    rdata = word;
         F3_BU:   rdata = {24'd0, byte_s};
         F3_HU:   rdata = {16'd0, half_s};
         default: rdata = 32'd0;
      endcase
   end

   // Store merge: read-modify-write of the addressed lane(s).
   always_comb begin
      merged = word;
      case (funct3)
         F3_B: begin
            case (byte_off)
               2'd0:    merged = {word[31:8], wdata[7:0]};
               2'd1:    merged = {word[31:16], wdata[7:0], word[7:0]};
               2'd2:    merged = {word[31:24], wdata[7:0], word[15:0]};
               2'd3:    merged = {wdata[7:0], word[23:0]};
               default: merged = word;
            endcase
         end
         F3_H: begin
            if (byte_off[1]) begin
               merged = {wdata[15:0], word[15:0]};
            end else begin
               merged = {word[31:16], wdata[15:0]};
            end
         end
         F3_W:    merged = wdata;
         default: merged = word;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Sequences CPU loads/stores onto a word-wide memory (combinational read,
//   synchronous write) and shares that port with a word-write loader.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     req_valid/req_ready       CPU request handshake
//     req_we/req_funct3         store flag and RV32 access type
//     req_addr/req_wdata        byte address and store data
//     resp_valid/rdata/err      one-cycle completion pulse, load data, error flag
//     ld_valid/ld_ready         loader handshake (priority over the CPU)
//     ld_addr/ld_wdata          loader word index and data
//     mem_we/mem_addr/mem_wd    memory write enable, word index, write data
//     mem_rd                    memory read data (combinational)
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [2:0]                req_funct3,
   input  logic [ADDRESS_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   output logic                      resp_valid,
   output logic [DATA_WIDTH-1:0]     resp_rdata,
   output logic                      resp_err,
   input  logic                      ld_valid,
   output logic                      ld_ready,
   input  logic [MEM_ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0]     ld_wdata,
   output logic                      mem_we,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wd,
   input  logic [DATA_WIDTH-1:0]     mem_rd
);

   state_t                      state_r;
   logic                        we_r;
   logic [2:0]                  funct3_r;
   logic [MEM_ADDR_WIDTH+1:0]   addr_r;      // only bits that reach memory are kept
   logic [DATA_WIDTH-1:0]       wdata_r;
   logic [MEM_ADDR_WIDTH-1:0]   ld_addr_r;
   logic [DATA_WIDTH-1:0]       ld_wdata_r;
   logic                        ld_sel_r;    // last accepted request came from the loader
   logic                        resp_valid_r;
   logic [DATA_WIDTH-1:0]       resp_rdata_r;
   logic                        resp_err_r;

   logic                        req_fire_s;
   logic                        ld_fire_s;
   logic                        req_err_s;
   logic [DATA_WIDTH-1:0]       lane_rdata_s;
   logic [DATA_WIDTH-1:0]       lane_merged_s;
   logic                        unused_addr_hi_s;

   // Upper address bits wrap modulo the memory size and are not used.
   assign unused_addr_hi_s = ^req_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH+2];

   assign req_err_s  = access_illegal(req_we, req_funct3, req_addr[1:0]);
   assign req_fire_s = req_valid & req_ready;
   assign ld_fire_s  = ld_valid & ld_ready;

   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;

   dmem_lane u_lane (
      .funct3   (funct3_r),
      .byte_off (addr_r[1:0]),
      .word     (mem_rd),
      .wdata    (wdata_r),
      .rdata    (lane_rdata_s),
      .merged   (lane_merged_s)
   );

   // Handshake readiness: only in IDLE out of reset, loader wins ties.
   always_comb begin
      ld_ready  = 1'b0;
      req_ready = 1'b0;
      if (!rst && state_r == IDLE) begin
         ld_ready  = 1'b1;
         req_ready = !ld_valid;
      end else begin
         ld_ready  = 1'b0;
         req_ready = 1'b0;
      end
   end

   // Memory port drive: address/data follow the last latched request, write only in ACCESS/LDWR.
   always_comb begin
      mem_we = 1'b0;
      if (ld_sel_r) begin
         mem_addr = ld_addr_r;
         mem_wd   = ld_wdata_r;
      end else begin
         mem_addr = addr_r[MEM_ADDR_WIDTH+1:2];
         mem_wd   = lane_merged_s;
      end
      if (rst) begin
         mem_we = 1'b0;
      end else begin
         case (state_r)
            ACCESS:  mem_we = we_r;
            LDWR:    mem_we = 1'b1;
            default: mem_we = 1'b0;
         endcase
      end
   end

   // Controller FSM with request latches and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         we_r         <= 1'b0;
         funct3_r     <= 3'd0;
         addr_r       <= '0;
         wdata_r      <= '0;
         ld_addr_r    <= '0;
         ld_wdata_r   <= '0;
         ld_sel_r     <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= '0;
         resp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               resp_valid_r <= 1'b0;
               if (ld_fire_s) begin
                  ld_addr_r  <= ld_addr;
                  ld_wdata_r <= ld_wdata;
                  ld_sel_r   <= 1'b1;
                  state_r    <= LDWR;
               end else if (req_fire_s) begin
                  we_r     <= req_we;
                  funct3_r <= req_funct3;
                  addr_r   <= req_addr[MEM_ADDR_WIDTH+1:0];
                  wdata_r  <= req_wdata;
                  ld_sel_r <= 1'b0;
                  if (req_err_s) begin
                     // Rejected accesses bypass ACCESS and answer one cycle later.
                     resp_valid_r <= 1'b1;
                     resp_err_r   <= 1'b1;
                     resp_rdata_r <= '0;
                     state_r      <= RESP;
                  end else begin
                     state_r <= ACCESS;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            ACCESS: begin
               resp_valid_r <= 1'b1;
               resp_err_r   <= 1'b0;
               resp_rdata_r <= we_r ? '0 : lane_rdata_s;
               state_r      <= RESP;
            end
            RESP: begin
               resp_valid_r <= 1'b0;
               state_r      <= IDLE;
            end
            LDWR: begin
               resp_valid_r <= 1'b0;
               state_r      <= IDLE;
            end
            default: begin
               resp_valid_r <= 1'b0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [9:0]  ld_addr = 10'd0;
   logic [31:0] ld_wdata = 32'd0;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] mem_arr [0:1023];   // memory attached to the DUT
   logic [31:0] ref_mem [0:1023];   // reference model's view of memory

   int pass_cnt = 0;
   int total_cnt = 0;
   int we_count = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   assign mem_rd = mem_arr[mem_addr];

   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wd;
   end

   always @(negedge clk) begin
      if (mem_we === 1'b1) we_count = we_count + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   task automatic timeout_fail(input string name);
      total_cnt++;
      $display("FAIL %s: got timeout, want handshake/response", name);
   endtask

   // ---------------- reference model (byte-addressed arithmetic) ----------------
   function automatic int acc_size(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         2'd2:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      int sz;
      sz = acc_size(f3);
      if (sz == 0) return 1'b1;
      if ((int'(addr[1:0]) % sz) != 0) return 1'b1;
      if (f3[2] && (we || sz == 4)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
      longint w, v, m;
      int sz, sh;
      sz = acc_size(f3);
      sh = 8 * int'(addr[1:0]);
      w  = longint'(ref_mem[addr[11:2]]);
      m  = (longint'(1) << (8 * sz)) - 1;
      v  = (w >> sh) & m;
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~m;
      return v[31:0];
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] w;
      int sz;
      sz = acc_size(f3);
      w  = ref_mem[addr[11:2]];
      for (int i = 0; i < sz; i++) w[8*(int'(addr[1:0])+i) +: 8] = wdata[8*i +: 8];
      ref_mem[addr[11:2]] = w;
   endtask

   // ---------------- drivers ----------------
   task automatic wait_ready(input bit for_ld, output int n);
      n = 0;
      while (((for_ld ? ld_ready : req_ready) !== 1'b1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) timeout_fail(for_ld ? "ld_ready" : "req_ready");
   endtask

   task automatic ld_write(input logic [9:0] idx, input logic [31:0] data);
      int n;
      ld_valid = 1'b1; ld_addr = idx; ld_wdata = data;
      wait_ready(1'b1, n);
      @(posedge clk); #1 ld_valid = 1'b0;
      @(posedge clk); #1;
      ref_mem[idx] = data;
   endtask

   task automatic cpu_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit hold,
                         output logic [31:0] rd, output logic er, output int lat, output int gap);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      wait_ready(1'b0, gap);
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      lat = 0; rd = 32'd0; er = 1'b0;
      while (lat < 6) begin
         @(negedge clk);
         lat++;
         if (resp_valid === 1'b1) break;
      end
      if (resp_valid !== 1'b1) begin
         timeout_fail("resp_valid");
         lat = 99;
      end else begin
         rd = resp_rdata;
         er = resp_err;
      end
   endtask

   // One operation checked against the reference model.
   task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit hold, output int gap);
      logic        e_err, g_err;
      logic [31:0] e_rd, g_rd;
      int          lat, w0;
      e_err = ref_err(we, f3, addr);
      e_rd  = (e_err || we) ? 32'd0 : ref_load(f3, addr);
      w0    = we_count;
      cpu_op(we, f3, addr, wdata, hold, g_rd, g_err, lat, gap);
      check_eq("rand_err", {31'd0, g_err}, {31'd0, e_err});
      check_eq("rand_rdata", g_rd, e_rd);
      check_eq("rand_latency", lat, e_err ? 32'd1 : 32'd2);
      check_eq("rand_mem_we_count", we_count - w0, (we && !e_err) ? 32'd1 : 32'd0);
      if (we && !e_err) ref_store(f3, addr, wdata);
      gap = gap + lat;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [17];

   initial begin
      logic [31:0] g_rd, tmp;
      logic        g_err;
      int          lat, gap, w0, n, rv_seen;

      vecs[0]  = '{1'b0, 3'b000, 32'h0000_0004, 32'h0, 32'hFFFF_FFAA, 1'b0}; // LB
      vecs[1]  = '{1'b0, 3'b100, 32'h0000_0005, 32'h0, 32'h0000_00F0, 1'b0}; // LBU
      vecs[2]  = '{1'b0, 3'b001, 32'h0000_0006, 32'h0, 32'hFFFF_8077, 1'b0}; // LH
      vecs[3]  = '{1'b0, 3'b101, 32'h0000_0006, 32'h0, 32'h0000_8077, 1'b0}; // LHU
      vecs[4]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0, 32'h8077_F0AA, 1'b0}; // LW
      vecs[5]  = '{1'b0, 3'b010, 32'h1000_1004, 32'h0, 32'h8077_F0AA, 1'b0}; // LW wrapped
      vecs[6]  = '{1'b1, 3'b000, 32'h0000_0009, 32'hFFFF_FFAB, 32'h0, 1'b0}; // SB
      vecs[7]  = '{1'b1, 3'b001, 32'h0000_000A, 32'h1234_BEEF, 32'h0, 1'b0}; // SH
      vecs[8]  = '{1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'hBEEF_AB44, 1'b0}; // LW
      vecs[9]  = '{1'b0, 3'b000, 32'h0000_000B, 32'h0, 32'hFFFF_FFBE, 1'b0}; // LB
      vecs[10] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 1'b1};         // LW misaligned
      vecs[11] = '{1'b1, 3'b001, 32'h0000_0003, 32'h5555_5555, 32'h0, 1'b1}; // SH misaligned
      vecs[12] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1'b1};         // funct3 011
      vecs[13] = '{1'b1, 3'b100, 32'h0000_0008, 32'h6666_6666, 32'h0, 1'b1}; // store BU form
      vecs[14] = '{1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'hBEEF_AB44, 1'b0}; // LW unchanged
      vecs[15] = '{1'b1, 3'b010, 32'h0000_000C, 32'hCAFE_0001, 32'h0, 1'b0}; // SW
      vecs[16] = '{1'b0, 3'b100, 32'h0000_000F, 32'h0, 32'h0000_00CA, 1'b0}; // LBU

      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;

      // Reset behaviour
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check_eq("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      rst = 1'b0;
      #1;
      check_eq("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      check_eq("post_rst_resp_rdata", resp_rdata, 32'd0);
      check_eq("post_rst_resp_err", {31'd0, resp_err}, 32'd0);

      // Preload through the loader port
      for (int i = 0; i < 32; i++) begin
         if (i == 1)      ld_write(10'(i), 32'h8077_F0AA);
         else if (i == 2) ld_write(10'(i), 32'h1122_3344);
         else             ld_write(10'(i), $urandom);
      end
      check_eq("preload_word1", mem_arr[1], 32'h8077_F0AA);

      // Directed vector table
      for (int v = 0; v < 17; v++) begin
         w0 = we_count;
         cpu_op(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].wdata, 1'b0, g_rd, g_err, lat, gap);
         check_eq($sformatf("vec%0d_rdata", v), g_rd, vecs[v].exp_rdata);
         check_eq($sformatf("vec%0d_err", v), {31'd0, g_err}, {31'd0, vecs[v].exp_err});
         check_eq($sformatf("vec%0d_latency", v), lat, vecs[v].exp_err ? 32'd1 : 32'd2);
         check_eq($sformatf("vec%0d_mem_we", v), we_count - w0,
                  (vecs[v].we && !vecs[v].exp_err) ? 32'd1 : 32'd0);
         if (vecs[v].we && !vecs[v].exp_err) ref_store(vecs[v].f3, vecs[v].addr, vecs[v].wdata);
         @(negedge clk);
         check_eq($sformatf("vec%0d_pulse_end", v), {31'd0, resp_valid}, 32'd0);
         check_eq($sformatf("vec%0d_rdata_held", v), resp_rdata, vecs[v].exp_rdata);
      end
      check_eq("word2_after_sb_sh", mem_arr[2], 32'hBEEF_AB44);
      check_eq("word3_after_sw", mem_arr[3], 32'hCAFE_0001);

      // Loader and CPU request in the same cycle
      @(negedge clk);
      tmp = $urandom;
      ld_valid = 1'b1; ld_addr = 10'd20; ld_wdata = tmp;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0050;
      #1;
      check_eq("arb_req_ready", {31'd0, req_ready}, 32'd0);
      check_eq("arb_ld_ready", {31'd0, ld_ready}, 32'd1);
      @(posedge clk); #1 ld_valid = 1'b0;
      @(negedge clk);
      check_eq("arb_ldwr_req_ready", {31'd0, req_ready}, 32'd0);
      check_eq("arb_ldwr_mem_we", {31'd0, mem_we}, 32'd1);
      @(negedge clk);
      check_eq("arb_idle_req_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1 req_valid = 1'b0;
      ref_mem[20] = tmp;
      n = 0;
      while (resp_valid !== 1'b1 && n < 6) begin @(negedge clk); n++; end
      if (resp_valid !== 1'b1) timeout_fail("arb_resp");
      else check_eq("arb_cpu_rdata", resp_rdata, tmp);

      // Reset while a store is in ACCESS
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0010;
      req_wdata = ~ref_mem[4];
      wait_ready(1'b0, n);
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rst_access_mem_we", {31'd0, mem_we}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      rv_seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) rv_seen++;
      end
      check_eq("rst_abort_no_resp", rv_seen, 32'd0);
      check_eq("rst_abort_mem_unchanged", mem_arr[4], ref_mem[4]);
      check_eq("rst_abort_req_ready", {31'd0, req_ready}, 32'd1);

      // Back-to-back LW/SW stream with req_valid held high
      for (int k = 0; k < 30; k++) begin
         model_op(1'($urandom_range(0, 1)), 3'b010, {20'd0, 7'($urandom_range(0, 31)), 5'd0} >> 3,
                  $urandom, (k < 29), gap);
         if (k > 0) check_eq("stream_resp_spacing", gap, 32'd3);
      end
      req_valid = 1'b0;

      // Randomized mixed accesses
      for (int k = 0; k < 80; k++) begin
         tmp = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
         model_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), tmp, $urandom, 1'b0, gap);
      end

      // Final memory image against the model
      @(negedge clk);
      for (int i = 0; i < 32; i++) check_eq($sformatf("final_word%0d", i), mem_arr[i], ref_mem[i]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
